hc08_chip_tester: RTL and testbench
===================================

// Module: hc08_chip_tester
// PURPOSE
//  Drives the inputs of a physical quad 2-input AND chip (74HC08 pinout) on the
//  breadboard and checks its outputs, i.e. the stimulus/checking end of the gate
//  interface. All four gates get exhaustive stimulus (A,B = 00,01,10,11); the block
//  reports one fail flag per gate plus an overall pass/done to the board LEDs.
// PARAMETERS
//  SETTLE_CYCLES  12   clk cycles to hold each vector before sampling (>=3; 1 us @ 12 MHz)
//  LOOP_GAP       12000000  idle cycles between runs, used only with HC08_LOOP_EN
// PORTS
//  clk        in   1  system clock (12 MHz board oscillator)
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  synchronous single-cycle start pulse (from debounced button)
//  dut_a      out  4  A inputs of gates 1..4 (chip pins 1,4,9,12), bit0 = gate1
//  dut_b      out  4  B inputs of gates 1..4 (chip pins 2,5,10,13)
//  dut_y      in   4  Y outputs of gates 1..4 (chip pins 3,6,8,11), asynchronous
//  busy       out  1  high while a test run is in progress
//  done       out  1  high once a run has completed; holds until next run starts
//  pass       out  1  valid when done: 1 = all four gates matched on all vectors
//  fail_gate  out  4  sticky per-gate mismatch flags for the current/last run
// BEHAVIOUR
//  - Reset: state=IDLE; dut_a=dut_b=0; busy=done=pass=0; fail_gate=0; vec=0; counters 0.
//  - dut_y passes a 2-flop synchronizer before comparison (2-cycle latency).
//  - States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
//    IDLE:   start=1 -> DRIVE; clear fail_gate, vec=0, done=0, pass=0; busy=1.
//    DRIVE:  1 cycle; dut_a={4{vec[1]}}, dut_b={4{vec[0]}}; load settle counter -> SETTLE.
//    SETTLE: count SETTLE_CYCLES cycles, then -> SAMPLE.
//    SAMPLE: 1 cycle; fail_gate |= synced_y ^ (dut_a & dut_b);
//            vec<3: vec++ -> DRIVE; vec==3: -> DONE.
//    DONE:   busy=0, done=1, pass=(fail_gate==4'b0); dut_a/dut_b return to 0.
//            start=1 -> same action as in IDLE (new run).
//  - Per-vector time = SETTLE_CYCLES+2 cycles; start pulse to done=1 = 4*(SETTLE_CYCLES+2)+1.
//  - vec is a 2-bit counter; it never wraps during a run (exit at 3).
//  - start while busy=1 is ignored; the run continues unaffected.
//  - rst_n low mid-run: immediate return to reset values; no partial result retained.
//  - SETTLE_CYCLES<3 is illegal (synchronizer would sample stale data).
// CONFIGURATION
//  - HC08_LOOP_EN defined: in DONE, count LOOP_GAP cycles, then auto-start a new run
//    (done/pass/fail_gate cleared at restart exactly as on start); start also restarts early.
//  - HC08_LOOP_EN undefined: DONE holds indefinitely until start; LOOP_GAP unused.
// TESTING (SETTLE_CYCLES=4)
//  - Good chip model y=a&b, pulse start -> busy=1 next cycle; done=1, pass=1,
//    fail_gate=4'b0000 exactly 25 cycles after start.
//  - Gate 3 stuck-at-0 -> fail on vec 3 only; done: pass=0, fail_gate=4'b0100.
//  - Gate 1 stuck-at-1 -> fails vecs 0..2; done: pass=0, fail_gate=4'b0001.
//  - NAND chip fitted (y=~(a&b)) -> fail_gate=4'b1111, pass=0.
//  - rst_n low during vec 2, release, pulse start -> all outputs 0 during reset;
//    fresh run gives pass=1 after 25 cycles; extra start pulses while busy ignored.
//  - HC08_LOOP_EN, LOOP_GAP=10 -> second run begins 10 cycles after done; done drops, re-asserts.

Source files
------------

// File: rtl/hc08_chip_tester_if.sv
// rtl/hc08_chip_tester_if.sv - control, status and chip-pin bundle for the 74HC08 tester
interface hc08_chip_tester_if;
   logic       start;
   logic [3:0] dut_a;
   logic [3:0] dut_b;
   logic [3:0] dut_y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_gate;

   modport master (
      input  start, dut_y,
      output dut_a, dut_b, busy, done, pass, fail_gate
   );

   modport slave (
      output start, dut_y,
      input  dut_a, dut_b, busy, done, pass, fail_gate
   );
endinterface

// File: rtl/hc08_chip_tester.sv
// rtl/hc08_chip_tester.sv - exhaustive 4-vector tester for a quad 2-input AND chip
// Optional HC08_LOOP_EN: auto-restart a run LOOP_GAP cycles after completion.
module hc08_chip_tester #(
   parameter int SETTLE_CYCLES = 12,
   parameter int LOOP_GAP      = 12000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hc08_chip_tester_if.master   bus
);
   localparam int SW = $clog2(SETTLE_CYCLES);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

   state_t         state, state_nxt;
   logic [1:0]     vec;
   logic [SW-1:0]  settle_cnt;
   logic [3:0]     y_s1, y_s2;
   logic [3:0]     err;
   logic           run_start;
   logic           gap_expired;

`ifdef HC08_LOOP_EN
   localparam int GW = $clog2(LOOP_GAP + 1);
   logic [GW-1:0] gap_cnt;

   assign gap_expired = (state == DONE) && (gap_cnt == GW'(LOOP_GAP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (state != DONE) begin
         gap_cnt <= '0;
      end else if (!gap_expired) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end
`else
   assign gap_expired = 1'b0;
`endif

   // The chip output is asynchronous to clk; settle time hides the 2-cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_s1 <= '0;
         y_s2 <= '0;
      end else begin
         y_s1 <= bus.dut_y;
         y_s2 <= y_s1;
      end
   end

   assign err = y_s2 ^ (bus.dut_a & bus.dut_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_start = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = DRIVE;
               run_start = 1'b1;
            end
         end
         DRIVE:  state_nxt = SETTLE;
         SETTLE: if (settle_cnt == '0) state_nxt = SAMPLE;
         SAMPLE: state_nxt = (vec == 2'd3) ? DONE : DRIVE;
         DONE: begin
            if (bus.start || gap_expired) begin
               state_nxt = DRIVE;
               run_start = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec           <= '0;
         settle_cnt    <= '0;
         bus.dut_a     <= '0;
         bus.dut_b     <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.pass      <= 1'b0;
         bus.fail_gate <= '0;
      end else begin
         if (run_start) begin
            vec           <= '0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail_gate <= '0;
         end
         case (state)
            DRIVE: begin
               bus.dut_a  <= {4{vec[1]}};
               bus.dut_b  <= {4{vec[0]}};
               settle_cnt <= SW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            SAMPLE: begin
               bus.fail_gate <= bus.fail_gate | err;
               if (vec == 2'd3) begin
                  // pass must be valid on the same cycle done rises, so fold in this vector's errors
                  bus.busy  <= 1'b0;
                  bus.done  <= 1'b1;
                  bus.pass  <= ((bus.fail_gate | err) == 4'b0);
                  bus.dut_a <= '0;
                  bus.dut_b <= '0;
               end else begin
                  vec <= vec + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_hc08_chip_tester.sv
// tb/tb_hc08_chip_tester.sv - scoreboard bench for hc08_chip_tester with a fault-injecting chip model
module tb_hc08_chip_tester;
   localparam int SETTLE = 4;
   localparam int LAT    = 4 * (SETTLE + 2) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hc08_chip_tester_if ifc();

   hc08_chip_tester #(.SETTLE_CYCLES(SETTLE), .LOOP_GAP(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.master)
   );

   // per-gate chip behaviour, 2 bits each: 0 good AND, 1 stuck-at-0, 2 stuck-at-1, 3 NAND
   logic [7:0] modes = 8'h00;

   function automatic logic [3:0] chip_y(input logic [7:0] m, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] y;
      for (int g = 0; g < 4; g++) begin
         case (m[2*g +: 2])
            2'd0:    y[g] = a[g] & b[g];
            2'd1:    y[g] = 1'b0;
            2'd2:    y[g] = 1'b1;
            default: y[g] = ~(a[g] & b[g]);
         endcase
      end
      return y;
   endfunction

   assign ifc.dut_y = chip_y(modes, ifc.dut_a, ifc.dut_b);

   typedef struct {
      logic [3:0] fg;
      logic       pass;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic exp_t model(input logic [7:0] m);
      exp_t e;
      int   mode, a, b, y;
      e.fg = 4'b0;
      for (int v = 0; v < 4; v++) begin
         a = v / 2;
         b = v % 2;
         for (int g = 0; g < 4; g++) begin
            mode = (m >> (2 * g)) % 4;
            if (mode == 0)      y = a * b;
            else if (mode == 1) y = 0;
            else if (mode == 2) y = 1;
            else                y = 1 - a * b;
            if (y != a * b) e.fg[g] = 1'b1;
         end
      end
      e.pass = (e.fg == 4'b0);
      return e;
   endfunction

   int   mon_cyc = 0;
   bit   mon_armed = 1'b0;
   bit   mon_done_q = 1'b0;
   exp_t mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_armed  = 1'b0;
            mon_done_q = 1'b0;
         end else begin
            if (mon_armed) begin
               mon_cyc++;
               if (mon_cyc == 1) check("busy_after_start", {31'b0, ifc.busy}, 32'd1);
               if (ifc.done && !mon_done_q) begin
                  mon_armed = 1'b0;
                  if (sbq.size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL unexpected_done: got done=1 want no run pending");
                  end else begin
                     mon_e = sbq.pop_front();
                     check("latency", mon_cyc, LAT);
                     check("fail_gate", {28'b0, ifc.fail_gate}, {28'b0, mon_e.fg});
                     check("pass", {31'b0, ifc.pass}, {31'b0, mon_e.pass});
                     check("busy_at_done", {31'b0, ifc.busy}, 32'd0);
                     check("pins_idle", {24'b0, ifc.dut_a, ifc.dut_b}, 32'd0);
                  end
               end
            end
            if (ifc.start && !ifc.busy) begin
               mon_armed = 1'b1;
               mon_cyc   = 0;
            end
            mon_done_q = ifc.done;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'b0, ifc.busy}, 32'd0);
      check({tag, "_done"}, {31'b0, ifc.done}, 32'd0);
      check({tag, "_pass"}, {31'b0, ifc.pass}, 32'd0);
      check({tag, "_fail_gate"}, {28'b0, ifc.fail_gate}, 32'd0);
      check({tag, "_pins"}, {24'b0, ifc.dut_a, ifc.dut_b}, 32'd0);
   endtask

   task automatic run(input logic [7:0] m, input bit extra);
      int n;
      modes = m;
      sbq.push_back(model(m));
      pulse_start();
      if (extra) begin
         repeat (4) @(posedge clk);
         pulse_start();
         repeat (6) @(posedge clk);
         pulse_start();
      end
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: got no done after %0d cycles want done after %0d", n, LAT);
         sbq.delete();
      end
      repeat (3) @(negedge clk);
      check("done_holds", {31'b0, ifc.done}, 32'd1);
      check("idle_not_busy", {31'b0, ifc.busy}, 32'd0);
   endtask

   initial begin
      ifc.start = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("post_reset");

      run(8'h00, 1'b0);
      run(8'h10, 1'b0);
      run(8'h02, 1'b0);
      run(8'hFF, 1'b0);

      // abort a NAND-chip run during vec 2; nothing may survive the reset
      modes = 8'hFF;
      pulse_start();
      repeat (2 * (SETTLE + 2) + 3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("mid_run_reset");
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(8'h00, 1'b1);

      for (int i = 0; i < 8; i++) begin
         run(8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no summary want finish before 200000");
      $fatal(1);
   end
endmodule
